// File: rtl/dbg_pkg.sv
// Shared definitions for the program/debug port: controller states and the
// opcode values benches use to build test programs for the core.
package dbg_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        DUMP = 2'd2,
        DONE = 2'd3
    } dbg_state_e;

    localparam logic [5:0] HLT  = 6'h3f;
    localparam logic [5:0] ADDI = 6'h0a;

endpackage

// File: rtl/prog_debug_port_if.sv
// Word stream with valid/ready handshake and an end-of-packet marker. Used
// for both the incoming program and the outgoing register dump.
interface prog_debug_port_if;

    logic        valid;
    logic        ready;
    logic [31:0] data;
    logic        last;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/prog_debug_port.sv
// Bring-up port for the RISC core: loads a program into instruction memory,
// lets the core run until it raises HALTED, then streams the register file
// out word by word. A restart pulse in DONE rearms the port for a new load.
module prog_debug_port
    import dbg_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int NREGS  = 32,
    parameter int CYC_W  = 32,
    localparam int RI_W  = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic                clk1,
    input  logic                rst_n,
    prog_debug_port_if.slave    s,
    prog_debug_port_if.master   m,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [31:0]         mem_wdata,
    output logic                core_run,
    input  logic                core_halted,
    output logic [RI_W-1:0]     rf_addr,
    input  logic [31:0]         rf_rdata,
    input  logic                restart,
    output logic                ovf,
    output logic [CYC_W-1:0]    run_cycles
);

    localparam logic [ADDR_W-1:0] TOP_ADDR = '1;
    localparam logic [RI_W-1:0]   LAST_IDX = RI_W'(NREGS - 1);

    dbg_state_e        state;
    dbg_state_e        state_next;
    logic [ADDR_W-1:0] wr_addr;
    logic              ovf_q;
    logic [CYC_W-1:0]  cyc_q;
    logic              halted_q;
    logic [RI_W-1:0]   rd_idx;
    logic              mv_q;
    logic              ml_q;
    logic [31:0]       md_q;

    logic              s_rdy;
    logic              run;
    logic              load_accept;
    logic              dump_start;
    logic              dump_accept;
    logic              restart_go;

    // Next-state decode plus the per-state strobes the datapath acts on.
    always_comb begin
        state_next  = state;
        s_rdy       = 1'b0;
        run         = 1'b0;
        load_accept = 1'b0;
        dump_start  = 1'b0;
        dump_accept = 1'b0;
        restart_go  = 1'b0;
        case (state)
            LOAD: begin
                s_rdy       = 1'b1;
                load_accept = s.valid;
                if (s.valid && (s.last || wr_addr == TOP_ADDR)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                run = 1'b1;
                if (core_halted && !halted_q) begin
                    dump_start = 1'b1;
                    state_next = DUMP;
                end
            end
            DUMP: begin
                dump_accept = mv_q && m.ready;
                if (dump_accept && ml_q) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                restart_go = restart;
                if (restart) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

    // State register and the delayed halt flag used for rising-edge detection.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            halted_q <= 1'b0;
        end else begin
            state    <= state_next;
            halted_q <= core_halted;
        end
    end

    // Load address, overflow flag and saturating run-cycle counter.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
            ovf_q   <= 1'b0;
            cyc_q   <= '0;
        end else if (restart_go) begin
            wr_addr <= '0;
            ovf_q   <= 1'b0;
            cyc_q   <= '0;
        end else begin
            if (load_accept) begin
                wr_addr <= wr_addr + 1'b1;
                if (!s.last && wr_addr == TOP_ADDR) begin
                    ovf_q <= 1'b1;
                end
            end
            if (run && cyc_q != '1) begin
                cyc_q <= cyc_q + 1'b1;
            end
        end
    end

    // Dump streamer: register word 0 on the halt edge, then advance one
    // register per accepted beat, holding data steady while stalled.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_idx <= '0;
            mv_q   <= 1'b0;
            ml_q   <= 1'b0;
            md_q   <= '0;
        end else if (restart_go) begin
            rd_idx <= '0;
        end else if (dump_start) begin
            md_q   <= rf_rdata;
            mv_q   <= 1'b1;
            ml_q   <= (NREGS == 1);
            rd_idx <= RI_W'(1);
        end else if (dump_accept) begin
            if (ml_q) begin
                mv_q <= 1'b0;
            end else begin
                md_q   <= rf_rdata;
                ml_q   <= (rd_idx == LAST_IDX);
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

    assign s.ready    = s_rdy;
    assign core_run   = run;
    assign mem_we     = load_accept;
    assign mem_addr   = wr_addr;
    assign mem_wdata  = s.data;
    assign rf_addr    = rd_idx;
    assign ovf        = ovf_q;
    assign run_cycles = cyc_q;
    assign m.valid    = mv_q;
    assign m.data     = md_q;
    assign m.last     = ml_q;

endmodule

// File: tb/tb_prog_debug_port.sv
// Bench for prog_debug_port: a small behavioural core executes the loaded
// program, and a transaction-level model of the port predicts every output.
module tb_prog_debug_port;
    import dbg_pkg::*;

    localparam int AW    = 4;
    localparam int NR    = 32;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = 32;

    logic           clk1;
    logic           rst_n;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [31:0]    mem_wdata;
    logic           core_run;
    logic           core_halted;
    logic [4:0]     rf_addr;
    logic [31:0]    rf_rdata;
    logic           restart;
    logic           ovf;
    logic [CW-1:0]  run_cycles;

    prog_debug_port_if s_if ();
    prog_debug_port_if m_if ();

    prog_debug_port #(.ADDR_W(AW), .NREGS(NR), .CYC_W(CW)) dut (
        .clk1        (clk1),
        .rst_n       (rst_n),
        .s           (s_if),
        .m           (m_if),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .core_run    (core_run),
        .core_halted (core_halted),
        .rf_addr     (rf_addr),
        .rf_rdata    (rf_rdata),
        .restart     (restart),
        .ovf         (ovf),
        .run_cycles  (run_cycles)
    );

    initial begin
        clk1 = 1'b0;
        forever #5 clk1 = ~clk1;
    end

    // ---------------- behavioural core ----------------
    logic [31:0]   imem [DEPTH];
    logic [31:0]   regs [NR];
    logic [AW-1:0] pc;
    logic          core_hlt_q;
    bit            force_mode = 0;
    bit            force_val  = 0;
    bit            preload_req = 0;
    bit            bp_en = 0;

    assign core_halted = force_mode ? force_val : core_hlt_q;
    assign rf_rdata    = regs[rf_addr];

    // Instruction memory, register file and a one-instruction-per-cycle core.
    always @(posedge clk1) begin : core_model
        logic [31:0] w;
        w = imem[pc];
        if (mem_we) imem[mem_addr] <= mem_wdata;
        if (preload_req) for (int k = 0; k < NR; k++) regs[k] <= 32'(k);
        if (!core_run) begin
            pc <= '0;
            core_hlt_q <= 1'b0;
        end else if (!core_hlt_q) begin
            pc <= pc + 1'b1;
            case (w[31:26])
                ADDI:    if (w[20:16] != 5'd0) regs[w[20:16]] <= regs[w[25:21]] + {{16{w[15]}}, w[15:0]};
                6'h00:   if (w[15:11] != 5'd0) regs[w[15:11]] <= regs[w[25:21]] + regs[w[20:16]];
                HLT:     core_hlt_q <= 1'b1;
                default: ;
            endcase
        end
    end

    // ---------------- transaction-level port model ----------------
    dbg_state_e    mstate = LOAD;
    int            mwr = 0;
    bit            movf = 0;
    logic [CW-1:0] mcyc = '0;
    bit            mprev = 0;
    int            midx = 0;

    // Predicts phase, write pointer, overflow, run count and dump index.
    always @(posedge clk1 or negedge rst_n) begin : ref_model
        bit h;
        if (!rst_n) begin
            mstate = LOAD; mwr = 0; movf = 0; mcyc = '0; mprev = 0; midx = 0;
        end else begin
            h = (core_halted === 1'b1);
            case (mstate)
                LOAD: if (s_if.valid) begin
                    if (s_if.last) mstate = RUN;
                    else if (mwr == DEPTH - 1) begin movf = 1; mstate = RUN; end
                    mwr++;
                end
                RUN: begin
                    if (mcyc != '1) mcyc++;
                    if (h && !mprev) begin mstate = DUMP; midx = 0; end
                end
                DUMP: if (m_if.ready) begin
                    if (midx == NR - 1) mstate = DONE;
                    else midx++;
                end
                DONE: if (restart) begin mstate = LOAD; mwr = 0; movf = 0; mcyc = '0; end
                default: ;
            endcase
            mprev = h;
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int wr_cnt   = 0;
    int last_cnt = 0;
    logic [31:0]   dump_q [$];
    logic          last_q [$];
    logic [AW-1:0] wr_addr_q [$];
    logic [31:0]   prog [$];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Compares every DUT output with the model mid-cycle and logs handshakes.
    always @(negedge clk1) begin
        if (rst_n === 1'b1) begin
            checkOutput("s_ready", s_if.ready, mstate == LOAD);
            checkOutput("core_run", core_run, mstate == RUN);
            checkOutput("mem_we", mem_we, (mstate == LOAD) && s_if.valid);
            if (mem_we) checkOutput("mem_addr", mem_addr, mwr[AW-1:0]);
            checkOutput("mem_wdata", mem_wdata, s_if.data);
            checkOutput("m_valid", m_if.valid, mstate == DUMP);
            if (mstate == DUMP) begin
                checkOutput("m_data", m_if.data, regs[midx]);
                checkOutput("m_last", m_if.last, midx == NR - 1);
                checkOutput("rf_addr", rf_addr, (midx + 1) % NR);
            end
            checkOutput("ovf", ovf, movf);
            checkOutput("run_cycles", run_cycles, mcyc);
            if (mem_we) begin
                wr_cnt++;
                wr_addr_q.push_back(mem_addr);
            end
            if (m_if.valid && m_if.ready) begin
                dump_q.push_back(m_if.data);
                last_q.push_back(m_if.last);
                if (m_if.last) last_cnt++;
            end
        end
    end

    // Dump-side backpressure, random when enabled.
    initial begin
        m_if.ready = 1'b1;
        forever begin
            @(posedge clk1);
            #2;
            m_if.ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk1);
        #2;
    endtask

    task automatic genProg(input int n);
        logic [31:0] w;
        prog.delete();
        for (int i = 0; i < n - 1; i++) begin
            if ($urandom_range(0, 1) == 1)
                w = {ADDI, 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)), 16'($urandom)};
            else
                w = {6'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(1, 31)), 11'h0};
            prog.push_back(w);
        end
        prog.push_back({HLT, 26'h0});
    endtask

    task automatic applyStimulus(input int n_beats, input bit flag_last, input bit gaps);
        int g;
        for (int i = 0; i < n_beats; i++) begin
            if (gaps) begin
                g = $urandom_range(0, 2);
                s_if.valid = 1'b0;
                s_if.last  = 1'b0;
                repeat (g) tick(1);
            end
            s_if.valid = 1'b1;
            s_if.data  = (i < prog.size()) ? prog[i] : $urandom;
            s_if.last  = flag_last && (i == n_beats - 1);
            tick(1);
        end
        s_if.valid = 1'b0;
        s_if.last  = 1'b0;
    endtask

    task automatic waitDump(input int base_last, input int budget);
        int t;
        t = 0;
        while (last_cnt == base_last && t < budget) begin
            @(posedge clk1);
            t++;
        end
        #2;
        checkOutput("dump_complete", last_cnt != base_last, 1);
    endtask

    task automatic checkDump(input int base);
        checkOutput("dump_beats", dump_q.size() - base, NR);
        for (int i = 0; i < NR && base + i < dump_q.size(); i++) begin
            checkOutput("dump_word", dump_q[base + i], regs[i]);
            checkOutput("dump_last", last_q[base + i], i == NR - 1);
        end
    endtask

    task automatic doRestart();
        restart = 1'b1;
        tick(1);
        restart = 1'b0;
        checkOutput("restart_ovf", ovf, 0);
        checkOutput("restart_cycles", run_cycles, 0);
        checkOutput("restart_sready", s_if.ready, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin : main
        int lb, db, wb, t;
        rst_n = 1'b0; restart = 1'b0;
        s_if.valid = 1'b0; s_if.data = 32'h1234_5678; s_if.last = 1'b0;
        tick(2);
        checkOutput("rst_s_ready", s_if.ready, 1);
        checkOutput("rst_core_run", core_run, 0);
        checkOutput("rst_mem_we", mem_we, 0);
        checkOutput("rst_mem_addr", mem_addr, 0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'h1234_5678);
        checkOutput("rst_m_valid", m_if.valid, 0);
        checkOutput("rst_m_data", m_if.data, 0);
        checkOutput("rst_m_last", m_if.last, 0);
        checkOutput("rst_rf_addr", rf_addr, 0);
        checkOutput("rst_ovf", ovf, 0);
        checkOutput("rst_run_cycles", run_cycles, 0);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] reference program");
        preload_req = 1; tick(1); preload_req = 0;
        prog = '{32'h2801000a, 32'h28020014, 32'h28030019, 32'h0ce77800, 32'h00222000,
                 32'h0ce77800, 32'h0ce77800, 32'h00832800, 32'hfc000000};
        lb = last_cnt; db = dump_q.size();
        applyStimulus(9, 1, 0);
        checkOutput("ref_core_run", core_run, 1);
        for (int i = 0; i < 9; i++) checkOutput("ref_imem", imem[i], prog[i]);
        waitDump(lb, 400);
        checkOutput("ref_beats", dump_q.size() - db, NR);
        if (dump_q.size() >= db + NR) begin
            checkOutput("ref_r0", dump_q[db + 0], 0);
            checkOutput("ref_r1", dump_q[db + 1], 10);
            checkOutput("ref_r2", dump_q[db + 2], 20);
            checkOutput("ref_r3", dump_q[db + 3], 25);
            checkOutput("ref_r4", dump_q[db + 4], 30);
            checkOutput("ref_r5", dump_q[db + 5], 55);
            checkOutput("ref_last30", last_q[db + 30], 0);
            checkOutput("ref_last31", last_q[db + 31], 1);
        end
        doRestart();

        $display("[TB] random programs with backpressure");
        for (int it = 0; it < 4; it++) begin
            bp_en = 1;
            genProg($urandom_range(3, 12));
            lb = last_cnt; db = dump_q.size();
            applyStimulus(prog.size(), 1, 1);
            waitDump(lb, 400);
            checkDump(db);
            bp_en = 0;
            doRestart();
        end

        $display("[TB] stale halt");
        force_mode = 1; force_val = 1;
        genProg(4);
        lb = last_cnt; db = dump_q.size();
        applyStimulus(4, 1, 0);
        tick(5);
        restart = 1'b1; tick(1); restart = 1'b0;
        tick(25);
        checkOutput("stale_no_dump", m_if.valid, 0);
        checkOutput("stale_running", core_run, 1);
        force_val = 0;
        tick(3);
        force_val = 1;
        waitDump(lb, 200);
        checkDump(db);
        force_mode = 0;
        doRestart();

        $display("[TB] last beat at top address");
        genProg(DEPTH);
        lb = last_cnt; db = dump_q.size();
        applyStimulus(DEPTH, 1, 0);
        checkOutput("top_last_ovf", ovf, 0);
        checkOutput("top_last_run", core_run, 1);
        waitDump(lb, 400);
        checkDump(db);
        doRestart();

        $display("[TB] overflow");
        genProg(DEPTH);
        lb = last_cnt; db = dump_q.size(); wb = wr_cnt;
        applyStimulus(DEPTH + 2, 0, 0);
        checkOutput("ovf_flag", ovf, 1);
        checkOutput("ovf_writes", wr_cnt - wb, DEPTH);
        checkOutput("ovf_sready", s_if.ready, 0);
        waitDump(lb, 400);
        checkDump(db);
        doRestart();

        $display("[TB] reset during dump");
        genProg(5);
        lb = last_cnt; db = dump_q.size();
        applyStimulus(5, 1, 0);
        t = 0;
        while (dump_q.size() < db + 5 && t < 200) begin
            @(posedge clk1);
            t++;
        end
        checkOutput("mid_dump_reached", dump_q.size() >= db + 5, 1);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_m_valid", m_if.valid, 0);
        checkOutput("async_s_ready", s_if.ready, 1);
        checkOutput("async_core_run", core_run, 0);
        @(posedge clk1);
        #2;
        rst_n = 1'b1;
        tick(1);
        genProg(6);
        lb = last_cnt; db = dump_q.size(); wb = wr_cnt;
        applyStimulus(6, 1, 0);
        checkOutput("reload_writes", wr_cnt - wb, 6);
        if (wr_addr_q.size() > wb) checkOutput("reload_first_addr", wr_addr_q[wb], 0);
        waitDump(lb, 400);
        checkDump(db);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
